bus_master_arbiter: RTL and testbench
=====================================

# bus_master_arbiter

Two-master ownership arbiter for the serial system bus. It sits between two bus masters and the shared master-side port of the address-decoding slave arbiter. It grants bus ownership to one master at a time using round-robin fairness, and routes that master's serial handshake signals onto the shared bus. It forcibly reclaims the bus from an owner that stalls past a configurable timeout.

## Interface
- TIMEOUT, 255: idle cycles tolerated while granted before forced release; must be ≥1.
- clk  in  1  bus clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- m1_req, m2_req  in  1  master requests bus ownership; level, held until done
- m1_done, m2_done  in  1  owner releases bus; single-cycle pulse, ignored when not owner
- m1_grant, m2_grant  out  1  registered ownership grant
- m1_mode, m2_mode  in  1  master mode bit
- m1_wr_bus, m2_wr_bus  in  1  master serial write data
- m1_master_valid, m2_master_valid  in  1  master valid
- m1_master_ready, m2_master_ready  in  1  master ready
- m1_rd_bus, m2_rd_bus  out  1  serial read data returned to master
- m1_slave_ready, m2_slave_ready  out  1  slave ready returned to master
- m1_slave_valid, m2_slave_valid  out  1  slave valid returned to master
- bus_mode, bus_wr_bus, bus_master_valid, bus_master_ready  out  1  shared bus outputs, driven from owner
- bus_rd_bus, bus_slave_ready, bus_slave_valid  in  1  shared bus returns
- owner  out  2  2'b00 none, 2'b01 m1, 2'b10 m2; never 2'b11
- timeout_err  out  1  one-cycle pulse when ownership is revoked by timeout

## Operation
- FSM states: IDLE, GRANT1, GRANT2, HANDOFF.
- IDLE transitions:
  - Only m1_req → GRANT1.
  - Only m2_req → GRANT2.
  - Both requests → grant the master that is not last_owner.
  - Neither request → stay in IDLE.
- GRANTx transitions:
  - Exit to HANDOFF when mx_done=1, when mx_req=0, or when the timeout counter equals TIMEOUT.
  - On exit, last_owner ← x.
- HANDOFF: always → IDLE after one cycle; creates a mandatory dead cycle between owners.
- last_owner register: 1 bit, reset value m2, so m1 wins the first tie.
- Grants and owner are decoded from the registered state:
  - m1_grant=1 only in GRANT1; m2_grant=1 only in GRANT2.
  - owner = 01 in GRANT1, 10 in GRANT2, 00 otherwise.
- Datapath mux, purely combinational from state:
  - In GRANTx, bus_* outputs equal mx_* inputs, and mx_rd_bus/slave_ready/slave_valid equal bus_* returns.
  - The non-owner's returned signals are 0.
  - In IDLE and HANDOFF, all bus_* outputs and all returned signals are 0.
- Timeout counter:
  - Width $clog2(TIMEOUT+1).
  - Cleared on entry to GRANTx.
  - Cleared in any GRANTx cycle where owner master_valid=1 or bus_slave_valid=1; otherwise increments, saturating at TIMEOUT.
- timeout_err: registered; high only for the HANDOFF cycle that follows a timeout exit.
- Simultaneous exit causes (done plus timeout in the same cycle): done has priority and timeout_err stays 0.
- done or req pulse from the non-owner: no effect.
- The requester that was just released may re-request immediately; round-robin ensures the other pending master wins the next tie.

## Timing
- Reset: at a rising edge with rst=1:
  - state=IDLE, last_owner=m2, counter=0, timeout_err=0.
  - All grants and owner are 0, and all muxed outputs are 0 in the following cycle.
- Reset mid-transfer has the same effect; the interrupted master sees its grant drop at the next edge, with no HANDOFF cycle and no timeout_err.
- Grant latency: request seen in IDLE at edge n → grant high after edge n+1 (1 cycle).
- Release latency:
  - done sampled at edge n → grant low after edge n (HANDOFF).
  - IDLE after edge n+1.
  - Earliest next grant after edge n+2.
- Timeout: with no activity, exit occurs on the edge where counter==TIMEOUT, i.e. TIMEOUT+1 idle GRANTx cycles after entry. timeout_err is high for exactly the following cycle.
- Mux path: zero latency, combinational from state to outputs; no combinational path from any input to grant.

## Test plan
- Reset, then m1_req=1 only → m1_grant=1 and owner=01 one cycle later. With m1_wr_bus toggling, bus_wr_bus equals m1_wr_bus; m2_slave_valid stays 0 while bus_slave_valid=1.
- m1_req and m2_req asserted together from reset → m1 granted first. After m1_done: m1_grant=0, 1 HANDOFF cycle, IDLE, then m2_grant=1. With m1 re-requesting, the next grant goes to m1.
- TIMEOUT=4, m2 granted with no master_valid or slave_valid → forced release after 5 GRANT2 cycles; timeout_err=1 for exactly 1 cycle; owner=00.
- Activity during grant: pulse master_valid every 3 cycles with TIMEOUT=4 → no timeout over 50 cycles. Then m1_done and timeout coinciding → timeout_err=0.
- rst=1 asserted mid-GRANT2 → the next cycle has owner=00, all bus_* outputs 0, and timeout_err=0. After release with both requests pending, m1 wins.
- Non-owner m2_done pulses and m2_mode/m2_wr_bus toggling during GRANT1 → no state change and no effect on bus_* outputs.

Source files
------------

// File: rtl/bus_master_arbiter.sv
// Two-master round-robin bus ownership arbiter with serial handshake mux and stall timeout.
// Grant latency 1 cycle, mandatory HANDOFF dead cycle between owners; mux is combinational from state.
module bus_master_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       m1_done,
    input  logic       m2_done,
    output logic       m1_grant,
    output logic       m2_grant,
    input  logic       m1_mode,
    input  logic       m2_mode,
    input  logic       m1_wr_bus,
    input  logic       m2_wr_bus,
    input  logic       m1_master_valid,
    input  logic       m2_master_valid,
    input  logic       m1_master_ready,
    input  logic       m2_master_ready,
    output logic       m1_rd_bus,
    output logic       m2_rd_bus,
    output logic       m1_slave_ready,
    output logic       m2_slave_ready,
    output logic       m1_slave_valid,
    output logic       m2_slave_valid,
    output logic       bus_mode,
    output logic       bus_wr_bus,
    output logic       bus_master_valid,
    output logic       bus_master_ready,
    input  logic       bus_rd_bus,
    input  logic       bus_slave_ready,
    input  logic       bus_slave_valid,
    output logic [1:0] owner,
    output logic       timeout_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT1  = 2'd1,
        GRANT2  = 2'd2,
        HANDOFF = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;   // 0: m1 owned last, 1: m2 owned last
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            terr_q, terr_d;

    logic            own_req, own_done, own_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    // Signals of whichever master currently holds the bus.
    always_comb begin
        own_req  = 1'b0;
        own_done = 1'b0;
        own_act  = 1'b0;
        if (state_q == GRANT1) begin
            own_req  = m1_req;
            own_done = m1_done;
            own_act  = m1_master_valid | bus_slave_valid;
        end else if (state_q == GRANT2) begin
            own_req  = m2_req;
            own_done = m2_done;
            own_act  = m2_master_valid | bus_slave_valid;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m1_req && (!m2_req || last_q)) begin
                    state_d = GRANT1;
                end else if (m2_req) begin
                    state_d = GRANT2;
                end
            end
            GRANT1, GRANT2: begin
                if (own_act) begin
                    cnt_d = '0;
                end else if (cnt_q != TMAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Voluntary release wins over a coincident timeout.
                if (own_done || !own_req || (cnt_q == TMAX)) begin
                    state_d = HANDOFF;
                    last_d  = (state_q == GRANT2);
                    terr_d  = own_req && !own_done;
                end
            end
            HANDOFF: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign m1_grant    = (state_q == GRANT1);
    assign m2_grant    = (state_q == GRANT2);
    assign owner       = {m2_grant, m1_grant};
    assign timeout_err = terr_q;

    always_comb begin
        bus_mode         = 1'b0;
        bus_wr_bus       = 1'b0;
        bus_master_valid = 1'b0;
        bus_master_ready = 1'b0;
        m1_rd_bus        = 1'b0;
        m1_slave_ready   = 1'b0;
        m1_slave_valid   = 1'b0;
        m2_rd_bus        = 1'b0;
        m2_slave_ready   = 1'b0;
        m2_slave_valid   = 1'b0;
        if (state_q == GRANT1) begin
            bus_mode         = m1_mode;
            bus_wr_bus       = m1_wr_bus;
            bus_master_valid = m1_master_valid;
            bus_master_ready = m1_master_ready;
            m1_rd_bus        = bus_rd_bus;
            m1_slave_ready   = bus_slave_ready;
            m1_slave_valid   = bus_slave_valid;
        end else if (state_q == GRANT2) begin
            bus_mode         = m2_mode;
            bus_wr_bus       = m2_wr_bus;
            bus_master_valid = m2_master_valid;
            bus_master_ready = m2_master_ready;
            m2_rd_bus        = bus_rd_bus;
            m2_slave_ready   = bus_slave_ready;
            m2_slave_valid   = bus_slave_valid;
        end
    end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter (TIMEOUT=4): table of vectors plus timeout/activity sequences.
module tb_bus_master_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       m1_req, m2_req, m1_done, m2_done;
    logic       m1_grant, m2_grant;
    logic       m1_mode, m2_mode, m1_wr_bus, m2_wr_bus;
    logic       m1_master_valid, m2_master_valid, m1_master_ready, m2_master_ready;
    logic       m1_rd_bus, m2_rd_bus, m1_slave_ready, m2_slave_ready;
    logic       m1_slave_valid, m2_slave_valid;
    logic       bus_mode, bus_wr_bus, bus_master_valid, bus_master_ready;
    logic       bus_rd_bus, bus_slave_ready, bus_slave_valid;
    logic [1:0] owner;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_master_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .m1_req(m1_req), .m2_req(m2_req), .m1_done(m1_done), .m2_done(m2_done),
        .m1_grant(m1_grant), .m2_grant(m2_grant),
        .m1_mode(m1_mode), .m2_mode(m2_mode),
        .m1_wr_bus(m1_wr_bus), .m2_wr_bus(m2_wr_bus),
        .m1_master_valid(m1_master_valid), .m2_master_valid(m2_master_valid),
        .m1_master_ready(m1_master_ready), .m2_master_ready(m2_master_ready),
        .m1_rd_bus(m1_rd_bus), .m2_rd_bus(m2_rd_bus),
        .m1_slave_ready(m1_slave_ready), .m2_slave_ready(m2_slave_ready),
        .m1_slave_valid(m1_slave_valid), .m2_slave_valid(m2_slave_valid),
        .bus_mode(bus_mode), .bus_wr_bus(bus_wr_bus),
        .bus_master_valid(bus_master_valid), .bus_master_ready(bus_master_ready),
        .bus_rd_bus(bus_rd_bus), .bus_slave_ready(bus_slave_ready),
        .bus_slave_valid(bus_slave_valid),
        .owner(owner), .timeout_err(timeout_err)
    );

    // Observed bits: {m1_grant, m2_grant, owner[1:0], timeout_err, bus_wr_bus,
    //                 bus_mode, bus_master_valid, m1_slave_valid, m2_slave_valid, m1_rd_bus}
    typedef struct {
        logic        rst, r1, r2, d1, d2, mv1, sv, rd, wr1, wr2, md2;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [10:0] observed();
        return {m1_grant, m2_grant, owner, timeout_err, bus_wr_bus,
                bus_mode, bus_master_valid, m1_slave_valid, m2_slave_valid, m1_rd_bus};
    endfunction

    function automatic void add(input logic rst_v, r1, r2, d1, d2, mv1, sv, rd, wr1, wr2, md2,
                                input logic [10:0] exp);
        vec_t v;
        v.rst = rst_v; v.r1 = r1; v.r2 = r2; v.d1 = d1; v.d2 = d2; v.mv1 = mv1;
        v.sv = sv; v.rd = rd; v.wr1 = wr1; v.wr2 = wr2; v.md2 = md2; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst; m1_req = v.r1; m2_req = v.r2; m1_done = v.d1; m2_done = v.d2;
        m1_master_valid = v.mv1; bus_slave_valid = v.sv; bus_rd_bus = v.rd;
        m1_wr_bus = v.wr1; m2_wr_bus = v.wr2; m2_mode = v.md2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {10'd0, act}, {10'd0, exp});
    endtask

    initial begin
        vec_t idle_v;
        m1_mode = 1'b1; m1_master_ready = 1'b1; m2_master_ready = 1'b0;
        m2_master_valid = 1'b0; bus_slave_ready = 1'b1;

        //   rst r1 r2 d1 d2 mv1 sv rd wr1 wr2 md2  expected
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'b00000000000); // reset
        add(0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 11'b10010110101); // m1 granted
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 11'b10010010100);
        add(0, 1, 0, 0, 1, 1, 1, 0, 1, 0, 1, 11'b10010111100); // non-owner done ignored
        add(0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 11'b10010010100);
        add(0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 11'b00000000000); // m1 done -> HANDOFF
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'b00000000000); // IDLE
        add(0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 11'b01100110010); // tie -> m2
        add(0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 11'b00000000000); // m2 done
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 11'b00000000000); // IDLE
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 11'b10010010000); // tie -> m1
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 11'b00000000000); // reset mid GRANT1
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 11'b10010010000); // m1 wins after reset
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 11'b00000000000); // req drop -> HANDOFF
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 11'b00000000000);
        add(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 11'b01100000010); // m2 granted
        add(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 11'b00000000000); // reset mid GRANT2
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 11'b10010010000); // m1 wins after reset
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'b00000000000);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'b00000000000);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            step();
            check($sformatf("vec%0d", i), observed(), vecs[i].exp);
        end

        idle_v = vecs[vecs.size() - 1];

        // Stalled m2: forced release after 5 GRANT2 cycles, one-cycle timeout_err.
        drive(idle_v);
        m2_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("to_grant%0d", i), {m2_grant, timeout_err}, 2'b10);
        end
        step();
        check("to_release", {m2_grant, owner, timeout_err}, 4'b0001);
        m2_req = 1'b0;
        step();
        check("to_err_clear", {m2_grant, owner, timeout_err}, 4'b0000);

        // Periodic activity keeps m1 owning the bus.
        m1_req = 1'b1;
        step();
        check1("act_grant", m1_grant, 1'b1);
        for (int i = 0; i < 50; i++) begin
            m1_master_valid = (i % 3 == 0);
            step();
            check($sformatf("act_hold%0d", i), {m1_grant, timeout_err}, 2'b10);
        end

        // Done lands on the same edge as the timeout: no timeout_err.
        m1_master_valid = 1'b1;
        step();
        m1_master_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check1($sformatf("co_hold%0d", i), m1_grant, 1'b1);
        end
        m1_done = 1'b1;
        step();
        check("co_release", {m1_grant, owner, timeout_err}, 4'b0000);
        m1_done = 1'b0;
        m1_req  = 1'b0;
        step();
        check("co_idle", {m1_grant, owner, timeout_err}, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
